// File: rtl/axis_pkg.sv
// Shared constants and helpers for the AXI-Stream FIFO.
// Holds default parameters and the level-width function.
package axis_pkg;

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_USER_W = 1;
    localparam int DEF_DEPTH  = 16;

    // Bits needed to count 0..depth inclusive
    function automatic int lw_of(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/axis_fifo_ram.sv
// Simple dual-port storage for the stream FIFO.
// Synchronous write, asynchronous read, no reset on the array.
module axis_fifo_ram #(
    parameter int DW    = 10,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    // Write port: one entry per accepted beat
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/axis_fifo.sv
// AXI-Stream first-word-fall-through FIFO.
// Tracks beat level and stored end-of-line count.
module axis_fifo
    import axis_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int USER_W    = DEF_USER_W,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int AF_THRESH = DEPTH - 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     s_tvalid,
    output logic                     s_tready,
    input  logic [WIDTH-1:0]         s_tdata,
    input  logic [USER_W-1:0]        s_tuser,
    input  logic                     s_tlast,
    output logic                     m_tvalid,
    input  logic                     m_tready,
    output logic [WIDTH-1:0]         m_tdata,
    output logic [USER_W-1:0]        m_tuser,
    output logic                     m_tlast,
    output logic [lw_of(DEPTH)-1:0]  level,
    output logic [lw_of(DEPTH)-1:0]  pkt_count,
    output logic                     almost_full
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = lw_of(DEPTH);
    localparam int DW = WIDTH + USER_W + 1;

    localparam logic [LW-1:0] FULL = LW'(DEPTH);
    localparam logic [LW-1:0] AF_L = LW'(AF_THRESH);

    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          wr;
    logic          rd;
    logic          pk_inc;
    logic          pk_dec;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;

    assign s_tready    = (level != FULL) && !flush;
    assign m_tvalid    = (level != '0);
    assign wr          = s_tvalid && s_tready;
    assign rd          = m_tvalid && m_tready;
    assign pk_inc      = wr && s_tlast;
    assign pk_dec      = rd && m_tlast;
    assign almost_full = (level >= AF_L);

    assign wdata = {s_tlast, s_tuser, s_tdata};
    assign {m_tlast, m_tuser, m_tdata} = rdata;

    axis_fifo_ram #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (wr),
        .waddr (wptr),
        .wdata (wdata),
        .raddr (rptr),
        .rdata (rdata)
    );

    // Pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else if (flush) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr) wptr <= wptr + AW'(1);
            if (rd) rptr <= rptr + AW'(1);
        end
    end

    // Beat level: +1 write, -1 read, hold on both or neither
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level <= '0;
        end else if (flush) begin
            level <= '0;
        end else begin
            unique case ({wr, rd})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // Count of stored beats carrying tlast
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_count <= '0;
        end else if (flush) begin
            pkt_count <= '0;
        end else begin
            unique case ({pk_inc, pk_dec})
                2'b10:   pkt_count <= pkt_count + LW'(1);
                2'b01:   pkt_count <= pkt_count - LW'(1);
                default: pkt_count <= pkt_count;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_fifo.sv
// Scoreboard bench for axis_fifo (DEPTH=16, WIDTH=8).
// A queue model predicts handshakes, counters and data.
module tb_axis_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic       s_tvalid;
    logic       s_tready;
    logic [7:0] s_tdata;
    logic       s_tuser;
    logic       s_tlast;
    logic       m_tvalid;
    logic       m_tready;
    logic [7:0] m_tdata;
    logic       m_tuser;
    logic       m_tlast;
    logic [4:0] level;
    logic [4:0] pkt_count;
    logic       almost_full;

    int n_cmp = 0;
    int n_bad = 0;

    logic [9:0] q [$];

    always #5 clk = ~clk;

    axis_fifo #(
        .WIDTH     (8),
        .USER_W    (1),
        .DEPTH     (16),
        .AF_THRESH (14)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .s_tvalid    (s_tvalid),
        .s_tready    (s_tready),
        .s_tdata     (s_tdata),
        .s_tuser     (s_tuser),
        .s_tlast     (s_tlast),
        .m_tvalid    (m_tvalid),
        .m_tready    (m_tready),
        .m_tdata     (m_tdata),
        .m_tuser     (m_tuser),
        .m_tlast     (m_tlast),
        .level       (level),
        .pkt_count   (pkt_count),
        .almost_full (almost_full)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp,
                     $time);
        end
    endtask

    function automatic int mpkt();
        int c = 0;
        foreach (q[i]) if (q[i][9]) c++;
        return c;
    endfunction

    // One clock cycle: drive at negedge, check, model the edge
    task automatic cyc(input logic v, input logic [7:0] d,
                       input logic u, input logic l,
                       input logic rdy, input logic fl);
        logic er;
        logic wf;
        logic rf;
        s_tvalid = v;
        s_tdata  = d;
        s_tuser  = u;
        s_tlast  = l;
        m_tready = rdy;
        flush    = fl;
        #1;
        er = (q.size() != 16) && !fl;
        wf = v && er;
        rf = (q.size() != 0) && rdy;
        chk("s_tready", 32'(s_tready), 32'(er));
        chk("m_tvalid", 32'(m_tvalid), 32'(q.size() != 0));
        chk("level", 32'(level), 32'(q.size()));
        chk("pkt_count", 32'(pkt_count), 32'(mpkt()));
        chk("almost_full", 32'(almost_full), 32'(q.size() >= 14));
        if (q.size() != 0)
            chk("m_beat", 32'({m_tlast, m_tuser, m_tdata}), 32'(q[0]));
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            if (rf) void'(q.pop_front());
            if (wf) q.push_back({l, u, d});
        end
        @(negedge clk);
    endtask

    task automatic idle();
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic wr(input logic [7:0] d, input logic u, input logic l);
        cyc(1'b1, d, u, l, 1'b0, 1'b0);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 64) begin
            cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
            n++;
        end
        chk("drain_done", 32'(q.size()), 32'd0);
    endtask

    initial begin
        rst      = 1'b1;
        flush    = 1'b0;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        s_tuser  = 1'b0;
        s_tlast  = 1'b0;
        m_tready = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_mvalid", 32'(m_tvalid), 32'd0);
        chk("rst_af", 32'(almost_full), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        idle();

        // Fill to full; the 17th beat must be refused
        for (int i = 0; i < 17; i++) wr(8'(i), 1'b0, 1'b0);
        idle();
        chk("full_level", 32'(level), 32'd16);
        chk("full_head", 32'(m_tdata), 32'h00);

        // Drain in order, one per cycle
        drain();
        idle();
        chk("empty_mvalid", 32'(m_tvalid), 32'd0);

        // Simultaneous read and write at level 5
        for (int i = 0; i < 5; i++) wr(8'h20 + 8'(i), 1'b0, 1'b0);
        cyc(1'b1, 8'h30, 1'b0, 1'b0, 1'b1, 1'b0);
        idle();
        chk("rw_level5", 32'(level), 32'd5);
        for (int i = 0; i < 11; i++) wr(8'h40 + 8'(i), 1'b0, 1'b0);
        cyc(1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 1'b0);
        idle();
        chk("rw_full", 32'(level), 32'd15);
        drain();

        // Three lines of four beats
        for (int ln = 0; ln < 3; ln++)
            for (int b = 0; b < 4; b++)
                wr(8'(ln * 16 + b), b == 0, b == 3);
        idle();
        chk("pkt3", 32'(pkt_count), 32'd3);
        for (int b = 0; b < 4; b++) begin
            #1 chk("tuser_b", 32'(m_tuser), 32'(b == 0));
            cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        chk("pkt2", 32'(pkt_count), 32'd2);
        drain();

        // Flush with traffic on both sides
        for (int i = 0; i < 9; i++) wr(8'h60 + 8'(i), 1'b0, i == 4);
        chk("pre_flush", 32'(level), 32'd9);
        cyc(1'b1, 8'hAA, 1'b0, 1'b1, 1'b1, 1'b1);
        idle();
        chk("flush_level", 32'(level), 32'd0);
        chk("flush_pkt", 32'(pkt_count), 32'd0);

        // Asynchronous reset in the middle of a cycle
        for (int i = 0; i < 7; i++) wr(8'h70 + 8'(i), 1'b0, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("arst_level", 32'(level), 32'd0);
        chk("arst_pkt", 32'(pkt_count), 32'd0);
        chk("arst_mvalid", 32'(m_tvalid), 32'd0);
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        idle();

        // Random traffic against the scoreboard
        for (int i = 0; i < 400; i++)
            cyc($urandom_range(0, 1) == 1, 8'($urandom),
                1'($urandom), 1'($urandom),
                $urandom_range(0, 2) != 0, 1'b0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/axis_fifo.md
AXIS_FIFO -- requirements
Module: axis_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 8, tdata width in bits.
REQ-002 SHALL have parameter USER_W, default 1, tuser width in bits.
REQ-003 SHALL have parameter DEPTH, default 16, entry count; power of two, >= 2.
REQ-004 SHALL have parameter AF_THRESH, default DEPTH-2, almost_full level threshold.
REQ-005 SHALL use one clock and asynchronous active-high reset: clk  input  1  rising-edge clock.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 flush  input  1  synchronous clear of all stored beats.
REQ-008 s_tvalid  input  1  slave beat valid.
REQ-009 s_tready  output  1  slave ready.
REQ-010 s_tdata  input  WIDTH  slave data.
REQ-011 s_tuser  input  USER_W  slave user (start-of-frame).
REQ-012 s_tlast  input  1  slave end-of-line.
REQ-013 m_tvalid  output  1  master beat valid.
REQ-014 m_tready  input  1  master ready.
REQ-015 m_tdata  output  WIDTH  master data.
REQ-016 m_tuser  output  USER_W  master user.
REQ-017 m_tlast  output  1  master end-of-line.
REQ-018 level  output  LW=$clog2(DEPTH+1)  stored beat count.
REQ-019 pkt_count  output  LW  stored beats with tlast=1.
REQ-020 almost_full  output  1  level >= AF_THRESH.

Function
REQ-021 Write SHALL occur when s_tvalid && s_tready; read SHALL occur when m_tvalid && m_tready.
REQ-022 s_tready SHALL be (level != DEPTH) && !flush; no write when full, even if a read occurs the same cycle.
REQ-023 m_tvalid SHALL be (level != 0); first-word-fall-through, m_tdata/m_tuser/m_tlast present the head entry combinationally from storage.
REQ-024 Write-to-m_tvalid latency SHALL be 1 cycle when empty; no same-cycle pass-through.
REQ-025 m_* payload SHALL hold stable while m_tvalid && !m_tready; payload is don't-care while m_tvalid=0.
REQ-026 Write and read pointers SHALL be $clog2(DEPTH) bits, wrapping DEPTH-1 -> 0.
REQ-027 level SHALL update +1 write only, -1 read only, unchanged both or neither; never exceeds DEPTH or underflows.
REQ-028 pkt_count SHALL +1 on write with s_tlast, -1 on read with m_tlast, unchanged when both; bounded by level.
REQ-029 almost_full SHALL be registered-consistent with level (derived combinationally from level register).
REQ-030 flush SHALL, at next edge, zero pointers, level and pkt_count, overriding any concurrent read or write; the beat presented that cycle is discarded (not acknowledged, s_tready=0).
REQ-031 Beat order and tdata/tuser/tlast association SHALL be preserved exactly.

Reset
REQ-032 On rst=1 asynchronously: pointers, level, pkt_count = 0; hence m_tvalid=0, almost_full=0 (AF_THRESH>0), s_tready=1 after release unless flush.
REQ-033 Storage array SHALL NOT be reset; reset mid-transfer SHALL drop all stored beats.

Structure
REQ-034 Package axis_pkg SHALL hold level-width helper function and default-parameter constants.
REQ-035 Storage SHALL be sub-module axis_fifo_ram: simple dual-port, synchronous write, asynchronous read, WIDTH+USER_W+1 bits x DEPTH.
REQ-036 Control (pointers, counters, handshake) SHALL stay in axis_fifo; no latches, single clock domain.

Verification
REQ-037 Fill: DEPTH=16, m_tready=0, write 16 beats 0x00..0x0F -> level=16, s_tready=0, almost_full=1 from level 14; 17th beat not accepted.
REQ-038 Drain: then m_tready=1 -> 0x00..0x0F out in order, one per cycle, level reaches 0, m_tvalid=0 after last.
REQ-039 Simultaneous: level=5, write and read same cycle -> level stays 5; level=16 with read+write -> write refused, level=15.
REQ-040 Packets: write 3 lines of 4 beats with tlast on 4th, tuser on first -> pkt_count=3; read 4 beats -> pkt_count=2, m_tuser=1 on beat 0 only.
REQ-041 Flush: level=9, assert flush with s_tvalid=1 and m_tready=1 -> next cycle level=0, pkt_count=0, m_tvalid=0, no beat accepted.
REQ-042 Reset mid-operation: level=7, pulse rst asynchronously mid-cycle -> outputs zero immediately; random valid/ready traffic after release matches scoreboard.
